// File: rtl/AHB_package.sv
// AHB_package: shared AHB transfer and response encodings.
package AHB_package;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_type;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_type;
endpackage

// File: rtl/ahb_default_slave_errlog.sv
// ahb_default_slave_errlog: first-error capture registers and saturating error counter.
module ahb_default_slave_errlog #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      log_hit,
  input  logic                      err_clear,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic                      hwrite,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);
  logic                      valid_q, valid_d, write_q, write_d, capture;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ERR_CNT_WIDTH-1:0]  count_q, count_d;
  // A hit coinciding with a clear starts a fresh log rather than being lost.
  assign capture = log_hit & (err_clear | ~valid_q);
  always_comb begin
    valid_d = log_hit | (valid_q & ~err_clear);
    addr_d  = capture ? haddr : err_clear ? '0 : addr_q;
    write_d = capture ? hwrite : ~err_clear & write_q;
    count_d = err_clear ? ERR_CNT_WIDTH'(log_hit)
            : (log_hit & ~&count_q) ? count_q + ERR_CNT_WIDTH'(1) : count_q;
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      count_q <= count_d;
    end
  end
  assign err_valid = valid_q;
  assign err_addr  = addr_q;
  assign err_write = write_q;
  assign err_count = count_q;
endmodule

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: decode-error slave giving two-cycle ERROR for NONSEQ/SEQ and OKAY otherwise.
module ahb_default_slave
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic                      hready,
  output logic                      hreadyout,
  output hresp_type                 hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      err_clear,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);
  typedef enum logic [1:0] {OK_ST, ERR1_ST, ERR2_ST} state_e;
  state_e state_q, state_d;
  logic   err_hit;
  assign err_hit = hsel & hready & (htrans == NONSEQ | htrans == SEQ);
  always_comb begin
    state_d   = state_q == ERR1_ST ? ERR2_ST : err_hit ? ERR1_ST : OK_ST;
    hreadyout = state_q != ERR1_ST;
    hresp     = state_q == OK_ST ? OKAY : ERROR;
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) state_q <= OK_ST;
    else           state_q <= state_d;
  end
  assign hrdata = '0;
  // Only hits that actually launch an ERROR response are logged.
  ahb_default_slave_errlog #(
    .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_errlog (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .log_hit  (err_hit & (state_q != ERR1_ST)),
    .err_clear(err_clear),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .err_valid(err_valid),
    .err_addr (err_addr),
    .err_write(err_write),
    .err_count(err_count)
  );
endmodule

// File: tb/tb_ahb_default_slave.sv
// tb_ahb_default_slave: directed plus random checks against a beat-queue/log reference model.
module tb_ahb_default_slave;
  import AHB_package::*;
  localparam int AW = 32, DW = 32, CW = 2, CMAX = 3;
  logic hclk = 1'b0, hreset_n = 1'b0, hsel = 1'b0, hwrite = 1'b0, err_clear = 1'b0;
  logic [AW-1:0] haddr = '0;
  htrans_type htrans = IDLE;
  logic hready, hreadyout, err_valid, err_write;
  hresp_type hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] err_count;
  assign hready = hreadyout;
  ahb_default_slave #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .err_clear(err_clear), .err_valid(err_valid), .err_addr(err_addr), .err_write(err_write),
    .err_count(err_count)
  );
  always #5 hclk = ~hclk;
  int errs = 0, checks = 0;
  typedef struct {logic rdy; hresp_type resp;} beat_t;
  beat_t beats[$];
  int m_count = 0;
  logic m_valid = 1'b0, m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_rdy();
    return beats.size() > 0 ? beats[0].rdy : 1'b1;
  endfunction
  function automatic hresp_type exp_resp();
    return beats.size() > 0 ? beats[0].resp : OKAY;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".hreadyout"}, 64'(hreadyout), 64'(exp_rdy()));
    chk({tag, ".hresp"}, 64'(hresp), 64'(exp_resp()));
    chk({tag, ".hrdata"}, 64'(hrdata), 64'd0);
    chk({tag, ".err_valid"}, 64'(err_valid), 64'(m_valid));
    chk({tag, ".err_addr"}, 64'(err_addr), 64'(m_addr));
    chk({tag, ".err_write"}, 64'(err_write), 64'(m_write));
    chk({tag, ".err_count"}, 64'(err_count), 64'(m_count));
  endtask
  task automatic model_reset();
    beats.delete();
    m_count = 0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0;
  endtask
  task automatic step(input string tag, input logic sel, input htrans_type trans,
                      input logic [AW-1:0] addr, input logic wr, input logic clr);
    logic hit;
    hsel = sel; htrans = trans; haddr = addr; hwrite = wr; err_clear = clr;
    hit = sel & exp_rdy() & (trans == NONSEQ || trans == SEQ);
    @(posedge hclk);
    if (beats.size() > 0) void'(beats.pop_front());
    if (hit) begin
      beats.push_back('{1'b0, ERROR});
      beats.push_back('{1'b1, ERROR});
    end
    if (hit && (clr || !m_valid)) begin
      m_valid = 1'b1; m_addr = addr; m_write = wr;
    end else if (clr) begin
      m_valid = 1'b0; m_addr = '0; m_write = 1'b0;
    end
    m_count = clr ? int'(hit) : hit ? (m_count + 1 > CMAX ? CMAX : m_count + 1) : m_count;
    #1;
    check_all(tag);
  endtask
  initial begin
    repeat (3) @(posedge hclk);
    #1;
    check_all("reset_hold");
    hreset_n = 1'b1;
    step("idle", 1'b1, IDLE, 32'h1000, 1'b0, 1'b0);
    step("busy", 1'b1, BUSY, 32'h1000, 1'b0, 1'b0);
    step("err1", 1'b1, NONSEQ, 32'h0800, 1'b1, 1'b0);
    step("err2", 1'b1, IDLE, 32'h0000, 1'b0, 1'b0);
    step("err_ok", 1'b1, IDLE, 32'h0000, 1'b0, 1'b0);
    step("b2b_clr", 1'b0, IDLE, 32'h0000, 1'b0, 1'b1);
    step("b2b_e1a", 1'b1, NONSEQ, 32'h0800, 1'b0, 1'b0);
    step("b2b_e2a", 1'b1, SEQ, 32'h0804, 1'b1, 1'b0);
    step("b2b_e1b", 1'b1, SEQ, 32'h0804, 1'b1, 1'b0);
    step("b2b_e2b", 1'b1, IDLE, 32'h0000, 1'b0, 1'b0);
    step("b2b_ok", 1'b1, IDLE, 32'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("sat_e1", 1'b1, NONSEQ, 32'h2000 + 32'(i * 4), i[0], 1'b0);
      step("sat_e2", 1'b0, IDLE, 32'h0000, 1'b0, 1'b0);
    end
    step("clr_only", 1'b0, IDLE, 32'h0000, 1'b0, 1'b1);
    step("clr_hit", 1'b1, NONSEQ, 32'h0C00, 1'b1, 1'b1);
    step("clr_hit2", 1'b1, NONSEQ, 32'h0D00, 1'b0, 1'b0);
    step("desel_e2", 1'b0, NONSEQ, 32'h0E00, 1'b0, 1'b0);
    step("rst_e1", 1'b1, NONSEQ, 32'h0F00, 1'b0, 1'b0);
    hreset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    step("rst_idle", 1'b1, IDLE, 32'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 3) != 0, htrans_type'($urandom_range(0, 3)),
           $urandom & ~32'h3, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
